// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO push arbiter: FSM state encoding and the
// width helper used for owner indices and beat counters.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_BURST = ST_BURST
    } state_t;

    // Ceiling log2 with a floor of one bit, so a width is never zero.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first asserted request found by searching
// upward from last_owner+1, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic               found,
    output logic [ID_W-1:0]    pick_idx
);

    int              cand;
    logic [ID_W-1:0] cidx;

    // Scan from farthest to nearest so the nearest hit after last_owner wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cidx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(last_owner) + i) % NUM_REQ;
            cidx = cand[ID_W-1:0];
            if (req[cidx]) begin
                found    = 1'b1;
                pick_idx = cidx;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one async FIFO write port between NUM_REQ producers. Whole bursts
// are granted round-robin; a burst ends on req_last or after MAX_BURST beats.
// Ownership is locked for the whole burst, even if the owner pauses.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 8,
    localparam int ID_W       = clog2_min1(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wpush,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_wfull,
    output logic                          busy,
    output logic [ID_W-1:0]               owner
);

    localparam int              CNT_W    = clog2_min1(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t          state;
    logic [ID_W-1:0] last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic            found;
    logic [ID_W-1:0] pick_idx;
    logic            accept;
    logic            burst_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .found      (found),
        .pick_idx   (pick_idx)
    );

    // A beat moves only while bursting, the owner has data and the FIFO has room.
    always_comb begin
        accept     = (state == S_BURST) && req[owner] && !fifo_wfull;
        burst_done = accept && (req_last[owner] || (beat_cnt == CNT_LAST));
    end

    // Route the owner's data to the FIFO and pulse its grant on each accepted beat.
    always_comb begin
        gnt        = '0;
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == ID_W'(i)) begin
                if (state == S_BURST) begin
                    fifo_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                if (accept) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

    assign fifo_wpush = accept;
    assign busy       = (state == S_BURST);

    // Burst FSM: one arbitration cycle in IDLE, then beats until last or MAX_BURST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (burst_done) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        state      <= S_IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios on an 8-beat build and a
// 1-beat build, plus a randomized run against a burst-level reference model.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_last, gnt;
    logic [N*DW-1:0] req_data;
    logic            fifo_wpush, fifo_wfull, busy;
    logic [DW-1:0]   fifo_wdata;
    logic [1:0]      owner;

    logic [N-1:0]    req1, req_last1, gnt1;
    logic [N*DW-1:0] req_data1;
    logic            wpush1, wfull1, busy1;
    logic [DW-1:0]   wdata1;
    logic [1:0]      owner1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .fifo_wpush(fifo_wpush), .fifo_wdata(fifo_wdata),
        .fifo_wfull(fifo_wfull), .busy(busy), .owner(owner)
    );

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .req_last(req_last1),
        .gnt(gnt1), .fifo_wpush(wpush1), .fifo_wdata(wdata1),
        .fifo_wfull(wfull1), .busy(busy1), .owner(owner1)
    );

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    function automatic logic [7:0] expv(input logic b, input logic p, input int g_idx, input int own);
        logic [3:0] g;
        logic [1:0] o;
        g = '0;
        if (g_idx >= 0) g[g_idx] = 1'b1;
        o = own[1:0];
        return {b, p, g, o};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data;
        req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_data1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0; req_last = '0; fifo_wfull = 1'b0;
        req1 = '0; req_last1 = '0; wfull1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'hF;
        req1 = 4'hF;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({busy, fifo_wpush, gnt, owner} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=00", {busy, fifo_wpush, gnt, owner});
        end
        total++;
        if ({busy1, wpush1, gnt1, owner1} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs_mb1 got=%h exp=00", {busy1, wpush1, gnt1, owner1});
        end
        tick();
        rst = 1'b0;
        req1 = '0;
    endtask

    task automatic test_round_robin;
        int own;
        for (int b = 0; b < 5; b++) begin
            own = b % N;
            @(negedge clk);
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== expv(0, 0, -1, (b == 0) ? 0 : (b - 1) % N)) begin
                bad++;
                $display("FAIL rr_idle b=%0d got=%h exp=%h", b, {busy, fifo_wpush, gnt, owner},
                         expv(0, 0, -1, (b == 0) ? 0 : (b - 1) % N));
            end
            tick();
            for (int k = 0; k < MB; k++) begin
                rand_data();
                @(negedge clk);
                total++;
                if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, own, own)) begin
                    bad++;
                    $display("FAIL rr_beat b=%0d k=%0d got=%h exp=%h", b, k,
                             {busy, fifo_wpush, gnt, owner}, expv(1, 1, own, own));
                end
                total++;
                if (fifo_wdata !== slice(req_data, own)) begin
                    bad++;
                    $display("FAIL rr_data b=%0d k=%0d got=%h exp=%h", b, k, fifo_wdata, slice(req_data, own));
                end
                tick();
            end
        end
    endtask

    task automatic test_last_short;
        int pushes;
        pushes = 0;
        do_reset();
        req = 4'b0100;
        tick();
        for (int k = 0; k < 3; k++) begin
            rand_data();
            req_last = (k == 2) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (fifo_wpush) pushes++;
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, 2, 2)) begin
                bad++;
                $display("FAIL last_beat k=%0d got=%h exp=%h", k, {busy, fifo_wpush, gnt, owner}, expv(1, 1, 2, 2));
            end
            total++;
            if (fifo_wdata !== slice(req_data, 2)) begin
                bad++;
                $display("FAIL last_data k=%0d got=%h exp=%h", k, fifo_wdata, slice(req_data, 2));
            end
            tick();
        end
        req = '0;
        req_last = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (fifo_wpush) pushes++;
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== expv(0, 0, -1, 2)) begin
                bad++;
                $display("FAIL last_after k=%0d got=%h exp=%h", k, {busy, fifo_wpush, gnt, owner}, expv(0, 0, -1, 2));
            end
            tick();
        end
        total++;
        if (pushes !== 3) begin
            bad++;
            $display("FAIL last_push_count got=%0d exp=3", pushes);
        end
    endtask

    task automatic test_wfull_stall;
        logic stall;
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 13; c++) begin
            stall = (c >= 3) && (c < 8);
            fifo_wfull = stall;
            rand_data();
            @(negedge clk);
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== (stall ? expv(1, 0, -1, 1) : expv(1, 1, 1, 1))) begin
                bad++;
                $display("FAIL stall_cycle c=%0d got=%h exp=%h", c, {busy, fifo_wpush, gnt, owner},
                         stall ? expv(1, 0, -1, 1) : expv(1, 1, 1, 1));
            end
            if (!stall) begin
                total++;
                if (fifo_wdata !== slice(req_data, 1)) begin
                    bad++;
                    $display("FAIL stall_data c=%0d got=%h exp=%h", c, fifo_wdata, slice(req_data, 1));
                end
            end
            tick();
        end
        fifo_wfull = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_burst_end got=%b exp=0", busy);
        end
        tick();
        req = '0;
    endtask

    task automatic test_owner_drop;
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 8; c++) begin
            rand_data();
            req      = (c < 2) ? 4'b0010 : (c < 6) ? 4'b1000 : (c == 6) ? 4'b1010 : 4'b1000;
            req_last = (c == 6) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            total++;
            if ({busy, fifo_wpush, gnt, owner} !==
                ((c < 2 || c == 6) ? expv(1, 1, 1, 1) : (c < 6) ? expv(1, 0, -1, 1) : expv(0, 0, -1, 1))) begin
                bad++;
                $display("FAIL drop_cycle c=%0d got=%h", c, {busy, fifo_wpush, gnt, owner});
            end
            tick();
        end
        req_last = 4'b1000;
        rand_data();
        @(negedge clk);
        total++;
        if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, 3, 3)) begin
            bad++;
            $display("FAIL drop_next_owner got=%h exp=%h", {busy, fifo_wpush, gnt, owner}, expv(1, 1, 3, 3));
        end
        total++;
        if (fifo_wdata !== slice(req_data, 3)) begin
            bad++;
            $display("FAIL drop_next_data got=%h exp=%h", fifo_wdata, slice(req_data, 3));
        end
        tick();
        req = '0;
        req_last = '0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        req = 4'b0001;
        req_last = 4'b0001;
        tick();
        @(negedge clk);
        total++;
        if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, 0, 0)) begin
            bad++;
            $display("FAIL rmid_first got=%h exp=%h", {busy, fifo_wpush, gnt, owner}, expv(1, 1, 0, 0));
        end
        tick();
        req = 4'hF;
        req_last = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, 1, 1)) begin
                bad++;
                $display("FAIL rmid_beat k=%0d got=%h exp=%h", k, {busy, fifo_wpush, gnt, owner}, expv(1, 1, 1, 1));
            end
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, fifo_wpush, gnt, owner} !== 8'h00) begin
            bad++;
            $display("FAIL rmid_async got=%h exp=00", {busy, fifo_wpush, gnt, owner});
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if ({busy, fifo_wpush, gnt, owner} !== expv(1, 1, 0, 0)) begin
            bad++;
            $display("FAIL rmid_restart got=%h exp=%h", {busy, fifo_wpush, gnt, owner}, expv(1, 1, 0, 0));
        end
        tick();
        req = '0;
    endtask

    task automatic test_max_burst_one;
        int own, prev;
        do_reset();
        req1 = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            own  = (g % 2 == 0) ? 1 : 3;
            prev = (g == 0) ? 0 : ((g % 2 == 0) ? 3 : 1);
            @(negedge clk);
            total++;
            if ({busy1, wpush1, gnt1, owner1} !== expv(0, 0, -1, prev)) begin
                bad++;
                $display("FAIL mb1_idle g=%0d got=%h exp=%h", g, {busy1, wpush1, gnt1, owner1}, expv(0, 0, -1, prev));
            end
            tick();
            rand_data();
            @(negedge clk);
            total++;
            if ({busy1, wpush1, gnt1, owner1} !== expv(1, 1, own, own)) begin
                bad++;
                $display("FAIL mb1_beat g=%0d got=%h exp=%h", g, {busy1, wpush1, gnt1, owner1}, expv(1, 1, own, own));
            end
            total++;
            if (wdata1 !== slice(req_data1, own)) begin
                bad++;
                $display("FAIL mb1_data g=%0d got=%h exp=%h", g, wdata1, slice(req_data1, own));
            end
            tick();
        end
        req1 = '0;
    endtask

    // Reference: a burst holder serves its beats until last/MAX_BURST; between
    // bursts the next holder is the nearest requester after the previous one.
    task automatic test_random;
        logic m_busy;
        int   m_owner, m_prev, m_beats, cand;
        logic acc;
        logic [7:0] e;
        do_reset();
        m_busy = 1'b0; m_owner = 0; m_prev = N - 1; m_beats = 0;
        for (int c = 0; c < 800; c++) begin
            for (int j = 0; j < N; j++) begin
                req[j]      = ($urandom_range(0, 9) < 6);
                req_last[j] = ($urandom_range(0, 3) == 0);
            end
            fifo_wfull = ($urandom_range(0, 4) == 0);
            rand_data();
            acc = m_busy && req[m_owner] && !fifo_wfull;
            e = expv(m_busy, acc, acc ? m_owner : -1, m_owner);
            @(negedge clk);
            total++;
            if ({busy, fifo_wpush, gnt, owner} !== e) begin
                bad++;
                $display("FAIL rand_ctrl c=%0d got=%h exp=%h", c, {busy, fifo_wpush, gnt, owner}, e);
            end
            if (acc) begin
                total++;
                if (fifo_wdata !== slice(req_data, m_owner)) begin
                    bad++;
                    $display("FAIL rand_data c=%0d got=%h exp=%h", c, fifo_wdata, slice(req_data, m_owner));
                end
            end
            if (!m_busy) begin
                cand = -1;
                for (int j = N; j >= 1; j--) begin
                    if (req[(m_prev + j) % N]) cand = (m_prev + j) % N;
                end
                if (cand >= 0) begin
                    m_busy = 1'b1; m_owner = cand; m_beats = 0;
                end
            end else if (acc) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0;
                    m_prev = m_owner;
                end
            end
            tick();
        end
        req = '0; req_last = '0; fifo_wfull = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_last = '0; req_data = '0; fifo_wfull = 1'b0;
        req1 = '0; req_last1 = '0; req_data1 = '0; wfull1 = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_last_short();
        test_wfull_stall();
        test_owner_drop();
        test_reset_mid();
        test_max_burst_one();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
